// File: rtl/alu_issue_ctrl.sv
// Issue controller between two requesters and a shared ALU: round-robin grant,
// one op in flight, divide wait with timeout, and a drain period after reset or timeout.
module alu_issue_ctrl #(
  parameter int WAIT_LIMIT   = 40,
  parameter int DRAIN_CYCLES = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [74:0] req_op0,
  input  logic [74:0] req_op1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        alu_is_imm,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic        alu_ready,
  input  logic [31:0] alu_out,
  input  logic        alu_done,
  output logic        busy
);

  typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic        is_imm;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] in2;
    logic [31:0] in1;
  } op_t;

  localparam int WCW = $clog2(WAIT_LIMIT + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(WAIT_LIMIT - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  state_t         state, state_nxt;
  op_t            op_q;
  logic           g_q;
  logic           last_grant;
  logic           grant;
  logic [WCW-1:0] wait_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [31:0]    result_q;
  logic           err_q;

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    rsp_valid  = '0;
    alu_ready  = 1'b0;
    grant      = 1'b0;
    alu_in1    = op_q.in1;
    alu_in2    = op_q.in2;
    alu_is_imm = op_q.is_imm;
    alu_funct3 = op_q.funct3;
    alu_funct7 = op_q.funct7;
    case (state)
      DRAIN: begin
        // Park the ALU on a DIV encoding with zero operands while old work flushes.
        alu_in1    = '0;
        alu_in2    = '0;
        alu_is_imm = 1'b0;
        alu_funct3 = 3'b100;
        alu_funct7 = 7'b0000001;
        if (drain_cnt == DRAIN_LAST) state_nxt = IDLE;
      end
      IDLE: begin
        alu_in1    = '0;
        alu_in2    = '0;
        alu_is_imm = 1'b0;
        alu_funct3 = 3'b000;
        alu_funct7 = 7'b0000000;
        // With both requesting, the one not served last wins.
        grant = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
        if (req_valid != 2'b00) begin
          req_ready[grant] = 1'b1;
          state_nxt        = ISSUE;
        end
      end
      ISSUE: begin
        alu_ready = 1'b1;
        state_nxt = alu_done ? RESP : WAIT;
      end
      WAIT: begin
        if (alu_done || wait_cnt == WAIT_LAST) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid[g_q] = 1'b1;
        if (rsp_ready[g_q]) state_nxt = err_q ? DRAIN : IDLE;
      end
      default: state_nxt = DRAIN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DRAIN;
      op_q       <= '0;
      g_q        <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      drain_cnt  <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        DRAIN: drain_cnt <= (drain_cnt == DRAIN_LAST) ? '0 : drain_cnt + DCW'(1);
        IDLE: begin
          if (req_valid != 2'b00) begin
            op_q <= grant ? op_t'(req_op1) : op_t'(req_op0);
            g_q  <= grant;
          end
        end
        ISSUE: begin
          err_q    <= 1'b0;
          wait_cnt <= '0;
          if (alu_done) result_q <= alu_out;
        end
        WAIT: begin
          if (alu_done) begin
            result_q <= alu_out;
          end else if (wait_cnt == WAIT_LAST) begin
            result_q <= '0;
            err_q    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        RESP: if (rsp_ready[g_q]) last_grant <= g_q;
        default: ;
      endcase
    end
  end

  assign rsp_data = result_q;
  assign rsp_err  = err_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU environment model, a timeline reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_issue_ctrl;

  localparam int WAIT_LIMIT   = 40;
  localparam int DRAIN_CYCLES = 34;
  localparam int DIV_LAT      = 33;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [74:0] req_op0;
  logic [74:0] req_op1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_is_imm;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic        alu_ready;
  logic [31:0] alu_out;
  logic        alu_done;
  logic        busy;

  alu_issue_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_is_imm(alu_is_imm),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7), .alu_ready(alu_ready),
    .alu_out(alu_out), .alu_done(alu_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [74:0] mk_op(logic imm, logic [6:0] f7, logic [2:0] f3,
                                        logic [31:0] in2, logic [31:0] in1);
    return {imm, f7, f3, in2, in1};
  endfunction

  function automatic logic is_div(logic [6:0] f7, logic [2:0] f3);
    return (f7 == 7'h01) && f3[2];
  endfunction

  // RISC-V style integer results, including divide-by-zero and overflow cases.
  function automatic logic [31:0] ref_alu(logic [6:0] f7, logic [2:0] f3,
                                          logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case ({f7, f3})
      {7'h00, 3'd0}: return a + b;
      {7'h20, 3'd0}: return a - b;
      {7'h00, 3'd4}: return a ^ b;
      {7'h00, 3'd6}: return a | b;
      {7'h00, 3'd7}: return a & b;
      {7'h01, 3'd0}: return a * b;
      {7'h01, 3'd4}: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      {7'h01, 3'd5}: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      {7'h01, 3'd6}: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      {7'h01, 3'd7}: return (b == 0) ? a : a % b;
      default:       return 32'h0;
    endcase
  endfunction

  function automatic logic [74:0] rand_op();
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] b;
    case ($urandom_range(0, 9))
      0: begin f7 = 7'h00; f3 = 3'd0; end
      1: begin f7 = 7'h20; f3 = 3'd0; end
      2: begin f7 = 7'h00; f3 = 3'd4; end
      3: begin f7 = 7'h00; f3 = 3'd6; end
      4: begin f7 = 7'h00; f3 = 3'd7; end
      5: begin f7 = 7'h01; f3 = 3'd0; end
      6: begin f7 = 7'h01; f3 = 3'd4; end
      7: begin f7 = 7'h01; f3 = 3'd5; end
      8: begin f7 = 7'h01; f3 = 3'd6; end
      default: begin f7 = 7'h01; f3 = 3'd7; end
    endcase
    b = $urandom;
    if (f7 == 7'h01 && $urandom_range(0, 7) == 0) b = 32'h0;
    return mk_op(1'($urandom_range(0, 1)), f7, f3, b, $urandom);
  endfunction

  // ALU environment: single-cycle ops report done at once, divides after DIV_LAT cycles.
  logic hang;
  logic stray;
  int   dcnt = 0;
  always @(posedge clk) begin
    if (alu_ready && is_div(alu_funct7, alu_funct3)) dcnt <= DIV_LAT;
    else if (dcnt != 0)                              dcnt <= dcnt - 1;
  end
  assign alu_out  = ref_alu(alu_funct7, alu_funct3, alu_in1, alu_in2);
  assign alu_done = stray | (!hang & (is_div(alu_funct7, alu_funct3) ? (dcnt == 1) : 1'b1));

  // Reference model: a timeline of cycle numbers for the single op in flight.
  int          m_cyc = 0;
  int          m_idle_at = 0;
  int          m_t_issue = 0;
  int          m_rsp_at = 0;
  bit          m_inflight = 0;
  bit          m_last = 1;
  bit          m_g = 0;
  logic [74:0] m_op = '0;
  logic [31:0] m_data = '0;
  bit          m_err = 0;
  logic [1:0]  m_granted = 2'b00;

  function automatic logic [1:0] pick(logic [1:0] v, bit last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  always @(negedge clk) begin : compare
    bit         idle, drain, issue, resp;
    logic [1:0] e_ready, e_rsp, w;
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_alu_ready", alu_ready, 0);
      check("rst_operands", {alu_in2, alu_in1}, 0);
      check("rst_busy", busy, 1);
      m_inflight = 0;
      m_last     = 1;
      m_granted  = 2'b00;
      m_idle_at  = m_cyc + 1 + DRAIN_CYCLES;
    end else begin
      idle    = !m_inflight && (m_cyc >= m_idle_at);
      drain   = !m_inflight && !idle;
      issue   = m_inflight && (m_cyc == m_t_issue);
      resp    = m_inflight && (m_cyc >= m_rsp_at);
      e_ready = idle ? pick(req_valid, m_last) : 2'b00;
      e_rsp   = resp ? (m_g ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", req_ready, e_ready);
      check("busy", busy, !idle);
      check("alu_ready", alu_ready, issue);
      check("rsp_valid", rsp_valid, e_rsp);
      if (resp) begin
        check("rsp_data", rsp_data, m_data);
        check("rsp_err", rsp_err, m_err);
      end
      if (m_inflight)
        check("alu_hold", {alu_is_imm, alu_funct7, alu_funct3, alu_in2, alu_in1}, m_op);
      else if (drain)
        check("alu_drain", {alu_is_imm, alu_funct7, alu_funct3, alu_in2, alu_in1},
              mk_op(1'b0, 7'h01, 3'd4, 32'h0, 32'h0));
      else
        check("alu_idle_add", {alu_is_imm, alu_funct7, alu_funct3}, 0);

      m_granted = 2'b00;
      if (idle && req_valid != 2'b00) begin
        w          = pick(req_valid, m_last);
        m_granted  = w;
        m_g        = w[1];
        m_op       = m_g ? req_op1 : req_op0;
        m_inflight = 1;
        m_t_issue  = m_cyc + 1;
        if (hang) begin
          m_rsp_at = m_t_issue + 1 + WAIT_LIMIT;
          m_data   = 32'h0;
          m_err    = 1;
        end else begin
          m_rsp_at = is_div(m_op[73:67], m_op[66:64]) ? m_t_issue + DIV_LAT + 1 : m_t_issue + 1;
          m_data   = ref_alu(m_op[73:67], m_op[66:64], m_op[31:0], m_op[63:32]);
          m_err    = 0;
        end
      end else if (resp && rsp_ready[m_g]) begin
        m_inflight = 0;
        m_last     = m_g;
        m_idle_at  = m_err ? m_cyc + 1 + DRAIN_CYCLES : m_cyc + 1;
      end
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (cnt < 300) begin
      @(negedge clk);
      if (req_ready != 2'b00) break;
      cnt++;
      tick();
    end
    check("ready_seen", req_ready != 2'b00, 1);
  endtask

  task automatic wait_rsp(output int cnt);
    cnt = 0;
    while (cnt < 300) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) break;
      cnt++;
      tick();
    end
    check("rsp_seen", rsp_valid != 2'b00, 1);
  endtask

  initial begin : stim
    int          c;
    logic [1:0]  pend;
    logic [74:0] pop [2];
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op0   = '0;
    req_op1   = '0;
    rsp_ready = 2'b00;
    hang      = 1'b0;
    stray     = 1'b0;
    pend      = 2'b00;
    pop[0]    = '0;
    pop[1]    = '0;
    repeat (3) @(posedge clk);
    #1;

    // Release reset with an ADD pending: drain, then 5 + 7.
    rst_n     = 1'b1;
    req_op0   = mk_op(1'b0, 7'h00, 3'd0, 32'd7, 32'd5);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    wait_ready(c);
    check("drain_len_post_reset", c, DRAIN_CYCLES);
    check("add_grant", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    check("add_issue_strobe", alu_ready, 1);
    check("add_no_early_rsp", rsp_valid, 0);
    tick();
    @(negedge clk);
    check("add_rsp_valid", rsp_valid, 2'b01);
    check("add_rsp_data", rsp_data, 32'd12);
    check("add_rsp_err", rsp_err, 0);
    tick();

    // DIV -100 / 7 from requester 1.
    req_op1   = mk_op(1'b0, 7'h01, 3'd4, 32'd7, 32'hFFFF_FF9C);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    wait_ready(c);
    check("div_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    wait_rsp(c);
    check("div_latency", c, 34);
    check("div_rsp_data", rsp_data, 32'hFFFF_FFF2);
    check("div_rsp_err", rsp_err, 0);
    tick();

    // Reset in the middle of a divide, then arbitration with both requesters.
    req_op1   = mk_op(1'b0, 7'h01, 3'd4, 32'd3, 32'd1000);
    req_valid = 2'b10;
    wait_ready(c);
    tick();
    req_valid = 2'b00;
    repeat (10) tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_busy", busy, 1);
    check("midreset_alu_ready", alu_ready, 0);
    tick();
    tick();
    rst_n     = 1'b1;
    req_op0   = mk_op(1'b0, 7'h00, 3'd0, 32'd2, 32'd1);
    req_op1   = mk_op(1'b0, 7'h00, 3'd0, 32'd20, 32'd10);
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    for (int k = 0; k < 4; k++) begin
      wait_ready(c);
      if (k == 0) check("drain_len_mid_div", c, DRAIN_CYCLES);
      check("arb_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
      tick();
      if (k == 0) begin
        wait_rsp(c);
        for (int j = 0; j < 5; j++) begin
          check("hold_rsp_valid", rsp_valid, 2'b01);
          check("hold_rsp_data", rsp_data, 32'd3);
          check("hold_no_grant", req_ready, 2'b00);
          tick();
          @(negedge clk);
        end
        tick();
        rsp_ready = 2'b11;
      end
    end
    req_valid = 2'b00;
    repeat (4) tick();

    // Timeout: the ALU never reports done.
    hang      = 1'b1;
    req_op0   = mk_op(1'b0, 7'h00, 3'd0, 32'd9, 32'd9);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    wait_ready(c);
    tick();
    req_valid = 2'b00;
    wait_rsp(c);
    check("timeout_latency", c, WAIT_LIMIT + 1);
    check("timeout_err", rsp_err, 1);
    check("timeout_data", rsp_data, 0);
    tick();
    hang      = 1'b0;
    req_op0   = mk_op(1'b0, 7'h00, 3'd0, 32'd3, 32'd2);
    req_valid = 2'b01;
    wait_ready(c);
    check("drain_len_timeout", c, DRAIN_CYCLES);
    tick();
    req_valid = 2'b00;
    repeat (3) tick();

    // Stray done pulses in IDLE and in RESP.
    stray = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("stray_idle_busy", busy, 0);
      check("stray_idle_rsp", rsp_valid, 0);
      tick();
    end
    stray     = 1'b0;
    req_op1   = mk_op(1'b0, 7'h01, 3'd4, 32'd7, 32'd77);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    wait_ready(c);
    tick();
    req_valid = 2'b00;
    wait_rsp(c);
    tick();
    stray = 1'b1;
    @(negedge clk);
    check("stray_resp_valid", rsp_valid, 2'b10);
    check("stray_resp_data", rsp_data, 32'd11);
    tick();
    stray     = 1'b0;
    rsp_ready = 2'b10;
    tick();
    tick();

    // Random traffic: requests held until granted, random accepts and stray pulses.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (m_granted[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pop[i]  = rand_op();
          pend[i] = 1'b1;
        end
      end
      req_valid = pend;
      req_op0   = pop[0];
      req_op1   = pop[1];
      rsp_ready = 2'($urandom_range(0, 3));
      stray     = !(m_inflight && m_cyc < m_rsp_at) && ($urandom_range(0, 7) == 0);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    stray     = 1'b0;
    repeat (120) tick();
    @(negedge clk);
    check("end_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 40: max ALU WAIT cycles before timeout.
REQ-002 Parameter DRAIN_CYCLES, default 34: length of DRAIN state.
REQ-003 clk  input  1  single clock; all state on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester op valid.
REQ-006 req_ready  output  2  per-requester op accept, one-hot or zero.
REQ-007 req_op0, req_op1  input  75 each  op {is_imm[74], funct7[73:67], funct3[66:64], in2[63:32], in1[31:0]}.
REQ-008 rsp_valid  output  2  per-requester result valid, one-hot or zero.
REQ-009 rsp_ready  input  2  per-requester result accept.
REQ-010 rsp_data  output  32  result, shared by both requesters.
REQ-011 rsp_err  output  1  result is a timeout, qualified by rsp_valid.
REQ-012 alu_in1, alu_in2  output  32 each  ALU operands.
REQ-013 alu_is_imm  output  1; alu_funct3  output  3; alu_funct7  output  7  ALU operator.
REQ-014 alu_ready  output  1  ALU start strobe.
REQ-015 alu_out  input  32  ALU result, combinational.
REQ-016 alu_done  input  1  ALU result valid: constant 1 for single-cycle ops, 1-cycle pulse for DIV/DIVU/REM/REMU.
REQ-017 busy  output  1  FSM not in IDLE.

Function
REQ-018 FSM states SHALL be DRAIN, IDLE, ISSUE, WAIT and RESP.
REQ-019 DRAIN: drive funct7=7'b0000001, funct3=3'b100, is_imm=0, operands 0, alu_ready=0; count DRAIN_CYCLES cycles, then go to IDLE. This lets any in-flight ALU division finish. Ignore alu_done.
REQ-020 IDLE: drive ADD (funct3=0, funct7=0, is_imm=0) with alu_ready=0. If any req_valid is set, grant exactly one requester g combinationally and assert req_ready[g].
REQ-021 Arbitration SHALL be round-robin. When both requesters are valid, the one not granted last wins. last_grant resets to 1, so requester 0 wins first.
REQ-022 On IDLE handshake: latch req_opg into the op register, record g, and go to ISSUE.
REQ-023 ISSUE (exactly 1 cycle): drive the ALU from the op register with alu_ready=1.
  - alu_done=1: capture alu_out, clear err, go to RESP.
  - Otherwise: clear the wait counter, go to WAIT.
REQ-024 WAIT: hold the ALU operands and operator unchanged, alu_ready=0.
  - alu_done=1: capture alu_out, go to RESP.
  - Else if counter==WAIT_LIMIT-1: result=0, err=1, go to RESP.
  - Else increment counter.
REQ-025 RESP: assert rsp_valid[g] with rsp_data/rsp_err held; ALU inputs stay held.
  - rsp_ready[g]=1: update last_grant=g; go to DRAIN if err, else IDLE.
  - rsp_ready of the non-granted requester SHALL be ignored.
REQ-026 ALU operands SHALL be stable from the ISSUE cycle through the cycle alu_done is sampled.
REQ-027 Latency, single-cycle op: handshake at edge t, ISSUE in cycle t+1, rsp_valid in cycle t+2.
REQ-028 Latency, divide op: ISSUE in cycle t+1, alu_done in cycle t+34, rsp_valid in cycle t+35.
REQ-029 req_ready SHALL be 0 in every state except IDLE; a request valid during busy waits and is not dropped.
REQ-030 An alu_done pulse outside ISSUE/WAIT SHALL be ignored.
REQ-031 rsp_valid SHALL stay asserted until accepted; no back-to-back overlap (max one op in flight).

Reset
REQ-032 rst_n low SHALL immediately force the following, regardless of state (including mid-division):
  - state=DRAIN, req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0;
  - alu_ready=0, alu operands 0, busy=1;
  - last_grant=1, counters 0.
REQ-033 After rst_n rises, the block SHALL spend DRAIN_CYCLES cycles in DRAIN before the first req_ready can assert.

Verification
REQ-034 Post-reset: rst_n low mid-division then released -> req_ready stays 0 for 34 cycles, then the first op is accepted.
REQ-035 ADD: req0 op in1=5, in2=7, funct3=0, funct7=0 -> rsp_valid[0]=1 two cycles after handshake, rsp_data=12, rsp_err=0.
REQ-036 DIV: req1 op in1=-100, in2=7, funct3=4, funct7=1, is_imm=0 -> rsp_data=-14 after 34 cycles.
  - alu_ready=1 in the ISSUE cycle only.
  - Operands stable throughout.
REQ-037 Arbitration: both req_valid held with ADD ops -> grants alternate 0,1,0,1; rsp_ready held 0 for 5 cycles on the first response -> rsp_valid/rsp_data held and no new grant.
REQ-038 Timeout: ALU model never asserts alu_done -> after 40 WAIT cycles rsp_err=1 and rsp_data=0; after acceptance the FSM enters DRAIN for 34 cycles.
REQ-039 Stray done: alu_done pulsed in IDLE and RESP -> no state change, no spurious rsp_valid.
